// File: rtl/vx_dispatch_arbiter_pkg.sv
// Shared types and helpers for the EX dispatch arbiter and its users.
package vx_dispatch_arbiter_pkg;

  localparam int DISP_DATAW = 64;

  typedef struct packed {
    logic                  valid;
    logic [DISP_DATAW-1:0] data;
  } dispatch_arb_req_t;

  function automatic int wis_to_wid(input int wis, input int isw, input int issue_cnt);
    return wis * issue_cnt + isw;
  endfunction

  // Slot-index width; a single slot still gets a 1-bit index.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_starve_arbiter.sv
// Round-robin arbiter with per-requester wait counters; a requester that has
// waited STARVE_LIMIT cycles overrides the round-robin order.
module vx_rr_starve_arbiter
  import vx_dispatch_arbiter_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int IDXW        = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                fire,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [IDXW-1:0]     grant_index,
  output logic                grant_valid
);

  localparam int CNTW = $clog2(STARVE_LIMIT + 1);
  localparam int CW   = IDXW + 1;
  localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

  logic [IDXW-1:0]                rr;
  logic [NUM_REQS-1:0][CNTW-1:0]  wait_cnt;
  logic [NUM_REQS-1:0]            starved;
  logic [CW-1:0]                  cand;

  always_comb begin
    grant_index = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQS; i++)
      starved[i] = requests[i] && (wait_cnt[i] == LIMIT);
    // Descending scans let the last hit (lowest index / nearest to rr) win.
    if (|starved) begin
      grant_valid = 1'b1;
      for (int i = NUM_REQS - 1; i >= 0; i--)
        if (starved[i]) grant_index = IDXW'(i);
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        cand = {1'b0, rr} + CW'(k);
        if (cand >= CW'(NUM_REQS)) cand = cand - CW'(NUM_REQS);
        if (requests[cand[IDXW-1:0]]) begin
          grant_index = cand[IDXW-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant_index] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr       <= '0;
      wait_cnt <= '0;
    end else begin
      if (fire)
        rr <= (grant_index == IDXW'(NUM_REQS - 1)) ? '0 : grant_index + IDXW'(1);
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!requests[i] || (fire && grant_onehot[i]))
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != LIMIT)
          wait_cnt[i] <= wait_cnt[i] + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/vx_dispatch_arbiter.sv
// Shares one EX dispatch port among ISSUE_CNT slots: registered output with
// skid-free full throughput, winning slot index attached, stall perf counter.
module vx_dispatch_arbiter
  import vx_dispatch_arbiter_pkg::*;
#(
  parameter int ISSUE_CNT    = 4,
  parameter int DATAW        = 64,
  parameter int STARVE_LIMIT = 8,
  parameter int PERF_W       = 44,
  localparam int ISW_W       = log2up(ISSUE_CNT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ISSUE_CNT-1:0]       in_valid,
  input  logic [ISSUE_CNT*DATAW-1:0] in_data,
  output logic [ISSUE_CNT-1:0]       in_ready,
  output logic                       out_valid,
  output logic [DATAW-1:0]           out_data,
  output logic [ISW_W-1:0]           out_isw,
  input  logic                       out_ready,
  output logic [PERF_W-1:0]          perf_stalls
);

  logic [ISSUE_CNT-1:0][DATAW-1:0] slot_data;
  logic [ISSUE_CNT-1:0]            grant_onehot;
  logic [ISW_W-1:0]                grant_index;
  logic                            grant_valid;
  logic                            can_load;
  logic                            fire;

  assign slot_data = in_data;
  assign can_load  = ~out_valid | out_ready;
  // Nothing is accepted while reset is held, even though grant is combinational.
  assign fire      = grant_valid & can_load & ~reset;
  assign in_ready  = grant_onehot & {ISSUE_CNT{can_load & ~reset}};

  vx_rr_starve_arbiter #(
    .NUM_REQS     (ISSUE_CNT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (in_valid),
    .fire         (fire),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_isw   <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= slot_data[grant_index];
      out_isw   <= grant_index;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      perf_stalls <= '0;
    else if (|in_valid && !(|in_ready))
      perf_stalls <= perf_stalls + PERF_W'(1);
  end

endmodule

// File: tb/tb_vx_dispatch_arbiter.sv
// Bench for vx_dispatch_arbiter: per-cycle vector table plus a packet scoreboard.
module tb_vx_dispatch_arbiter;
  import vx_dispatch_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 44;
  localparam int NV = 29;
  localparam int NA = 17;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic            out_ready;

  logic [N-1:0]  in_ready_m, in_ready_s;
  logic          out_valid_m, out_valid_s;
  logic [DW-1:0] out_data_m, out_data_s;
  logic [1:0]    out_isw_m, out_isw_s;
  logic [PW-1:0] perf_m, perf_s;

  vx_dispatch_arbiter #(.ISSUE_CNT(N), .DATAW(DW), .STARVE_LIMIT(8), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_m),
    .out_valid(out_valid_m), .out_data(out_data_m), .out_isw(out_isw_m),
    .out_ready(out_ready), .perf_stalls(perf_m));

  vx_dispatch_arbiter #(.ISSUE_CNT(N), .DATAW(DW), .STARVE_LIMIT(2), .PERF_W(PW)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_isw(out_isw_s),
    .out_ready(out_ready), .perf_stalls(perf_s));

  logic          sel;
  logic [N-1:0]  rdy_x;
  logic          ov_x;
  logic [DW-1:0] data_x;
  logic [1:0]    isw_x;
  logic [PW-1:0] pf_x;
  assign rdy_x  = sel ? in_ready_s  : in_ready_m;
  assign ov_x   = sel ? out_valid_s : out_valid_m;
  assign data_x = sel ? out_data_s  : out_data_m;
  assign isw_x  = sel ? out_isw_s   : out_isw_m;
  assign pf_x   = sel ? perf_s      : perf_m;

  typedef struct {
    logic       sel;
    logic [3:0] v;
    logic       r;
    logic [3:0] rdy;
    logic       ov;
    int         pf;
  } vec_t;

  typedef struct {
    logic [1:0]    isw;
    logic [DW-1:0] data;
  } sb_t;

  vec_t              tbl [NV];
  sb_t               sbq [$];
  dispatch_arb_req_t req [N];
  int                seq [N];
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic drive(input logic [3:0] v, input logic r);
    in_valid  = v;
    out_ready = r;
    for (int s = 0; s < N; s++) begin
      req[s].valid = v[s];
      req[s].data  = {16'(s), 16'hD15A, 32'(seq[s])};
      in_data[s*DW +: DW] = req[s].data;
    end
  endtask

  task automatic run_row(input vec_t t, input int row);
    int w;
    w = oh2idx(t.rdy);
    sel = t.sel;
    drive(t.v, t.r);
    @(negedge clk);
    chk($sformatf("in_ready[%0d]", row), 64'(rdy_x), 64'(t.rdy));
    chk($sformatf("out_valid[%0d]", row), 64'(ov_x), 64'(t.ov));
    chk($sformatf("perf_stalls[%0d]", row), 64'(pf_x), 64'(t.pf));
    if (ov_x) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty[%0d]: got packet isw %0d want none", row, isw_x);
      end else begin
        chk($sformatf("out_isw[%0d]", row), 64'(isw_x), 64'(sbq[0].isw));
        chk($sformatf("out_data[%0d]", row), data_x, sbq[0].data);
        if (t.r) void'(sbq.pop_front());
      end
    end
    if (t.rdy != 4'b0000) sbq.push_back('{isw: 2'(w), data: req[w].data});
    @(posedge clk);
    #1;
    if (t.rdy != 4'b0000) seq[w]++;
  endtask

  initial begin
    for (int s = 0; s < N; s++) seq[s] = 0;
    // sel, in_valid, out_ready, expected in_ready, expected out_valid, expected perf
    tbl = '{
      // round-robin from reset, all requesting
      '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 0},
      '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 0},
      '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 0},
      '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 0},
      '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0},
      // single requester, slot 2
      '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 0},
      '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 0},
      '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 0},
      // EX unit stalls for 5 cycles
      '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 0},
      '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 1},
      '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2},
      '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 3},
      '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 4},
      '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 5},
      '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 5},
      '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 5},
      '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 5},
      // STARVE_LIMIT=2 instance after the reset pulse
      '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0, 0},
      '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b1, 0},
      '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b1, 1},
      '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 2},
      '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2},
      '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2},
      '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 2},
      '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 3},
      '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 4},
      '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 4},
      '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 4},
      '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4}
    };

    sel = 1'b0;
    drive(4'b1111, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid_m), 64'd0);
      chk("rst_in_ready", 64'(in_ready_m), 64'd0);
    end
    chk("rst_perf", 64'(perf_m), 64'd0);
    chk("rst_out_isw", 64'(out_isw_m), 64'd0);
    chk("rst_out_data", out_data_m, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NA; i++) run_row(tbl[i], i);

    // Async reset pulse between clock edges while a packet is held.
    drive(4'b0000, 1'b0);
    @(negedge clk);
    chk("pre_pulse_out_valid", 64'(out_valid_m), 64'd1);
    if (sbq.size() != 0) begin
      chk("pre_pulse_out_isw", 64'(out_isw_m), 64'(sbq[0].isw));
      chk("pre_pulse_out_data", out_data_m, sbq[0].data);
    end
    #1 reset = 1'b1;
    #1;
    chk("pulse_out_valid_m", 64'(out_valid_m), 64'd0);
    chk("pulse_out_valid_s", 64'(out_valid_s), 64'd0);
    chk("pulse_perf_m", 64'(perf_m), 64'd0);
    chk("pulse_perf_s", 64'(perf_s), 64'd0);
    chk("pulse_out_data", out_data_m, 64'd0);
    #1 reset = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;

    for (int i = NA; i < NV; i++) run_row(tbl[i], i);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
